// File: rtl/timebin_packer.sv
`default_nettype none
// ============================================================================
// Module   : timebin_packer
// Purpose  : Packs per-bin PMT counts into fixed-width words and clears the
//            counter after each capture. Completed words are handed off over a
//            valid/ready interface. Defining SATURATE_EN clamps oversized
//            counts to all-ones; otherwise they are truncated.
// Revision : 1.0  initial release
// ============================================================================
module timebin_packer #(
  parameter int IN_W          = 16,
  parameter int COUNT_W       = 4,
  parameter int BINS_PER_WORD = 4,
  parameter int OUT_W         = COUNT_W * BINS_PER_WORD
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               bin_end,
  input  logic [IN_W-1:0]    count_in,
  output logic               bin_clr,
  output logic [OUT_W-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               overrun,
  output logic               sat_flag
);

  localparam int IDX_W = (BINS_PER_WORD > 1) ? $clog2(BINS_PER_WORD) : 1;
  localparam logic [IN_W-1:0]  c_SAT_MAX  = IN_W'((64'd1 << COUNT_W) - 64'd1);
  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(BINS_PER_WORD - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [OUT_W-1:0]   shift_q, shift_d;
  logic [OUT_W-1:0]   hold_q, hold_d;
  logic               valid_q, valid_d;
  logic               clr_q, clr_d;
  logic               ovr_q, ovr_d;
  logic               sat_q, sat_d;

  logic               w_over;
  logic [COUNT_W-1:0] w_field;
  logic [OUT_W-1:0]   w_merged;
  logic               w_emit;
  logic [OUT_W-1:0]   w_emit_word;

  assign w_over = (count_in > c_SAT_MAX);

`ifdef SATURATE_EN
  assign w_field = w_over ? {COUNT_W{1'b1}} : count_in[COUNT_W-1:0];
`else
  assign w_field = count_in[COUNT_W-1:0];
`endif

  assign w_merged = shift_q | (OUT_W'(w_field) << (COUNT_W * int'(idx_q)));

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    valid_d     = valid_q;
    clr_d       = 1'b0;
    ovr_d       = ovr_q;
    sat_d       = sat_q;
    w_emit      = 1'b0;
    w_emit_word = shift_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          ovr_d   = 1'b0;
          sat_d   = 1'b0;
        end
      end
      S_RUN: begin
        if (bin_end) begin
          clr_d = 1'b1;
          if (w_over) sat_d = 1'b1;
          if (idx_q == c_LAST_IDX) begin
            idx_d       = '0;
            shift_d     = '0;
            w_emit      = 1'b1;
            w_emit_word = w_merged;
          end else begin
            idx_d   = idx_q + 1'b1;
            shift_d = w_merged;
          end
        end
        if (stop) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        // A word that completed on the stop cycle leaves idx at 0, so nothing is re-sent.
        w_emit  = (idx_q != '0);
        idx_d   = '0;
        shift_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (valid_q && out_ready) valid_d = 1'b0;

    // One-deep holding register: a new word loads unless the old one is still stuck.
    if (w_emit) begin
      if (valid_q && !out_ready) begin
        ovr_d = 1'b1;
      end else begin
        hold_d  = w_emit_word;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      shift_q <= '0;
      hold_q  <= '0;
      valid_q <= 1'b0;
      clr_q   <= 1'b0;
      ovr_q   <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      valid_q <= valid_d;
      clr_q   <= clr_d;
      ovr_q   <= ovr_d;
      sat_q   <= sat_d;
    end
  end

  assign bin_clr   = clr_q;
  assign out_data  = hold_q;
  assign out_valid = valid_q;
  assign busy      = (state_q == S_RUN) || (state_q == S_FLUSH);
  assign overrun   = ovr_q;
  assign sat_flag  = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_timebin_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_timebin_packer
// Purpose  : Directed self-checking bench for timebin_packer.
// Revision : 1.0  initial release
// ============================================================================
module tb_timebin_packer;

  logic        clk = 1'b0;
  logic        reset, start, stop, bin_end, out_ready;
  logic [15:0] count_in;
  logic        bin_clr, out_valid, busy, overrun, sat_flag;
  logic [15:0] out_data;

  int n_cmp = 0;
  int n_err = 0;
  int clr_cnt = 0;
  int val_cnt = 0;
  int clr_base, val_base;

  timebin_packer dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .bin_end  (bin_end),
    .count_in (count_in),
    .bin_clr  (bin_clr),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .overrun  (overrun),
    .sat_flag (sat_flag)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bin_clr)   clr_cnt <= clr_cnt + 1;
    if (out_valid) val_cnt <= val_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_bin(input logic [15:0] v);
    bin_end  = 1'b1;
    count_in = v;
    tick();
    bin_end  = 1'b0;
    count_in = 16'h0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; bin_end = 1'b0;
    out_ready = 1'b1; count_in = 16'h0;
    tick(); tick();
    reset = 1'b0;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data",  {16'd0, out_data}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_flags", {29'd0, overrun, sat_flag, bin_clr}, 32'd0);

    // bin_end in IDLE is ignored
    do_bin(16'd3);
    check("idle_noclr", {31'd0, bin_clr}, 32'd0);

    // Test 1: full word with ready consumer
    clr_base = clr_cnt; val_base = val_cnt;
    do_start();
    check("t1_busy", {31'd0, busy}, 32'd1);
    do_bin(16'd1);
    check("t1_clr_pulse", {31'd0, bin_clr}, 32'd1);
    do_bin(16'd2); do_bin(16'd3); do_bin(16'd4);
    check("t1_valid", {31'd0, out_valid}, 32'd1);
    check("t1_data",  {16'd0, out_data}, 32'h4321);
    tick(); tick();
    check("t1_valid_cycles", val_cnt - val_base, 32'd1);
    check("t1_clr_count",    clr_cnt - clr_base, 32'd4);
    do_stop(); tick();
    check("t1_noflush", {31'd0, out_valid}, 32'd0);

    // Test 2: oversized count
    do_start();
    do_bin(16'd20);
    check("t2_sat", {31'd0, sat_flag}, 32'd1);
    do_stop(); tick();
`ifdef SATURATE_EN
    check("t2_data", {16'd0, out_data}, 32'h000F);
`else
    check("t2_data", {16'd0, out_data}, 32'h0004);
`endif
    tick();

    // Test 3: partial flush and busy timing
    do_start();
    check("t3_sat_clr", {31'd0, sat_flag}, 32'd0);
    do_bin(16'd5); do_bin(16'd6);
    do_stop();
    check("t3_busy_flush", {31'd0, busy}, 32'd1);
    tick();
    check("t3_busy_idle", {31'd0, busy}, 32'd0);
    check("t3_valid", {31'd0, out_valid}, 32'd1);
    check("t3_data",  {16'd0, out_data}, 32'h0065);
    tick();

    // Test 4: stalled consumer, overrun
    out_ready = 1'b0;
    do_start();
    for (int i = 1; i <= 8; i++) do_bin(16'(i));
    check("t4_valid",   {31'd0, out_valid}, 32'd1);
    check("t4_data",    {16'd0, out_data}, 32'h4321);
    check("t4_overrun", {31'd0, overrun}, 32'd1);
    do_stop(); tick();
    out_ready = 1'b1;
    tick();
    check("t4_accepted", {31'd0, out_valid}, 32'd0);
    do_start();
    check("t4_ovr_clr", {31'd0, overrun}, 32'd0);
    do_stop(); tick();

    // Test 5: bin_end and stop on the same cycle
    do_start();
    do_bin(16'd7); do_bin(16'd8);
    stop = 1'b1;
    do_bin(16'd9);
    stop = 1'b0;
    tick();
    check("t5_valid", {31'd0, out_valid}, 32'd1);
    check("t5_data",  {16'd0, out_data}, 32'h0987);
    tick();

    // Test 6: reset mid-run, then start+stop together in IDLE
    do_start();
    do_bin(16'd1); do_bin(16'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_rst_clr",  {31'd0, bin_clr}, 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("t6_start_wins", {31'd0, busy}, 32'd1);
    do_bin(16'hA); do_bin(16'hB); do_bin(16'hC); do_bin(16'hD);
    check("t6_valid", {31'd0, out_valid}, 32'd1);
    check("t6_data",  {16'd0, out_data}, 32'hDCBA);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
